mcp3202_spi_slave: RTL and testbench

- Synthesizable SPI responder that emulates an MCP3202 12-bit ADC on the FPGA fabric.
- Lets the ADC SPI master be exercised in hardware loopback and in simulation without a physical converter.
- Oversamples the master's `cs`, `sck` and `mosi` with the system clock, decodes the 4-bit command (START, SGL/DIFF, ODD/SIGN, MSBF), latches a 12-bit sample from fabric inputs, and returns null bit + 12 data bits on `miso`.

---
 rtl/mcp3202_spi_slave.sv | 270 +++++++++++++++++++++++++++
 tb/tb_mcp3202_spi_slave.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/mcp3202_spi_slave.sv
//-----------------------------------------------------------------------------
// mcp3202_spi_slave
//   SPI responder emulating an MCP3202 12-bit ADC. cs/sck/mosi are
//   oversampled with clk. The 4-bit command (START, SGL/DIFF, ODD/SIGN, MSBF)
//   is decoded, a 12-bit sample is latched from the fabric inputs on the MSBF
//   edge, and a null bit followed by B11..B0 is returned on miso.
//
//   Optional feature macro: MCP3202_SLV_LSBF_TAIL_EN
//     defined     : MSBF=0 frames append the B1..B11 LSB-first tail.
//     not defined : every frame sends zeros after B0.
//
// Parameters
//   SYNC_STAGES  synchronizer depth on cs/sck/mosi (2..4)
//   RST_MISO     miso level while idle or in reset
//
// Ports
//   clk, rst_n            system clock, async active-low reset
//   cs, sck, mosi         SPI from master (asynchronous to clk)
//   miso, miso_oe         response bit and its output enable
//   ch0_data, ch1_data    12-bit channel samples
//   smpl_stb              1-clk pulse when the sample is latched
//   cfg_sgl/odd/msbf      last fully decoded configuration
//   frame_done            1-clk pulse: frame ended after B0 was driven
//   frame_abort           1-clk pulse: frame ended before B0 was driven
//   busy                  synchronized cs is low
//-----------------------------------------------------------------------------
`timescale 1ns/1ps
module mcp3202_spi_slave #(
   parameter int   SYNC_STAGES = 2,
   parameter logic RST_MISO    = 1'b0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cs,
   input  logic        sck,
   input  logic        mosi,
   output logic        miso,
   output logic        miso_oe,
   input  logic [11:0] ch0_data,
   input  logic [11:0] ch1_data,
   output logic        smpl_stb,
   output logic        cfg_sgl,
   output logic        cfg_odd,
   output logic        cfg_msbf,
   output logic        frame_done,
   output logic        frame_abort,
   output logic        busy
);

   typedef enum logic [2:0] {
      IDLE, WAIT_START, CFG, NULLB, DATA, TAIL_ZERO
`ifdef MCP3202_SLV_LSBF_TAIL_EN
      , TAIL_LSB
`endif
   } state_e;

   // ---------------------------------------------------------------- sync
   // cs/sck idle high, so their chains reset to 1 to avoid a false edge
   // when reset is released.
   logic [SYNC_STAGES-1:0] cs_sync_q, sck_sync_q, mosi_sync_q;
   // One extra flop past each chain: edges are formed from two fully
   // settled samples, never from the metastability-catching first stage.
   logic                   cs_prev_q, sck_prev_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cs_sync_q   <= '1;
         sck_sync_q  <= '1;
         mosi_sync_q <= '0;
         cs_prev_q   <= 1'b1;
         sck_prev_q  <= 1'b1;
      end else begin
         cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs};
         sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], sck};
         mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
         cs_prev_q   <= cs_sync_q[SYNC_STAGES-1];
         sck_prev_q  <= sck_sync_q[SYNC_STAGES-1];
      end
   end

   logic cs_s, sck_s, mosi_s;
   logic cs_fall, cs_rise, sck_rise, sck_fall;

   assign cs_s   = cs_sync_q[SYNC_STAGES-1];
   assign sck_s  = sck_sync_q[SYNC_STAGES-1];
   assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

   assign cs_fall  =  cs_prev_q & ~cs_s;
   assign cs_rise  = ~cs_prev_q &  cs_s;
   // Qualifying with cs_s low also makes a coincident cs rise win.
   assign sck_rise = ~sck_prev_q &  sck_s & ~cs_s;
   assign sck_fall =  sck_prev_q & ~sck_s & ~cs_s;

   // ---------------------------------------------------------------- state
   state_e      state_q, state_d;
   logic        miso_q, miso_d, oe_q, oe_d;
   logic [1:0]  cnt_q, cnt_d;
   logic [3:0]  idx_q, idx_d;
   logic        sgl_t_q, sgl_t_d, odd_t_q, odd_t_d;
   logic        cfg_sgl_q, cfg_sgl_d, cfg_odd_q, cfg_odd_d, cfg_msbf_q, cfg_msbf_d;
   logic [11:0] sample_q, sample_d;
   logic        stb_q, stb_d, done_q, done_d, abort_q, abort_d;
   logic        b0_q, b0_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         miso_q     <= RST_MISO;
         oe_q       <= 1'b0;
         cnt_q      <= '0;
         idx_q      <= '0;
         sgl_t_q    <= 1'b0;
         odd_t_q    <= 1'b0;
         cfg_sgl_q  <= 1'b0;
         cfg_odd_q  <= 1'b0;
         cfg_msbf_q <= 1'b0;
         sample_q   <= '0;
         stb_q      <= 1'b0;
         done_q     <= 1'b0;
         abort_q    <= 1'b0;
         b0_q       <= 1'b0;
      end else begin
         state_q    <= state_d;
         miso_q     <= miso_d;
         oe_q       <= oe_d;
         cnt_q      <= cnt_d;
         idx_q      <= idx_d;
         sgl_t_q    <= sgl_t_d;
         odd_t_q    <= odd_t_d;
         cfg_sgl_q  <= cfg_sgl_d;
         cfg_odd_q  <= cfg_odd_d;
         cfg_msbf_q <= cfg_msbf_d;
         sample_q   <= sample_d;
         stb_q      <= stb_d;
         done_q     <= done_d;
         abort_q    <= abort_d;
         b0_q       <= b0_d;
      end
   end

   // ---------------------------------------------------------------- next state
   always_comb begin
      state_d = state_q;
      if (state_q != IDLE && cs_rise) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE:       if (cs_fall) state_d = WAIT_START;
            WAIT_START: if (sck_rise && mosi_s) state_d = CFG;
            CFG:        if (sck_rise && cnt_q == 2'd2) state_d = NULLB;
            NULLB:      if (sck_fall) state_d = DATA;
            DATA: begin
               if (sck_fall && idx_q == 4'd0) begin
`ifdef MCP3202_SLV_LSBF_TAIL_EN
                  state_d = cfg_msbf_q ? TAIL_ZERO : TAIL_LSB;
`else
                  state_d = TAIL_ZERO;
`endif
               end
            end
`ifdef MCP3202_SLV_LSBF_TAIL_EN
            TAIL_LSB:   if (sck_fall && idx_q == 4'd11) state_d = TAIL_ZERO;
`endif
            default:    state_d = state_q;
         endcase
      end
   end

   // ---------------------------------------------------------------- sample select
   // Differential results are formed 13-bit signed; negatives clamp to zero.
   logic [12:0] diff;
   logic [11:0] smpl_new;

   always_comb begin
      if (odd_t_q) diff = {1'b0, ch1_data} - {1'b0, ch0_data};
      else         diff = {1'b0, ch0_data} - {1'b0, ch1_data};
      if (sgl_t_q) smpl_new = odd_t_q ? ch1_data : ch0_data;
      else         smpl_new = diff[12] ? 12'h000 : diff[11:0];
   end

   // ---------------------------------------------------------------- outputs
   always_comb begin
      miso_d     = miso_q;
      oe_d       = oe_q;
      cnt_d      = cnt_q;
      idx_d      = idx_q;
      sgl_t_d    = sgl_t_q;
      odd_t_d    = odd_t_q;
      cfg_sgl_d  = cfg_sgl_q;
      cfg_odd_d  = cfg_odd_q;
      cfg_msbf_d = cfg_msbf_q;
      sample_d   = sample_q;
      stb_d      = 1'b0;
      done_d     = 1'b0;
      abort_d    = 1'b0;
      b0_d       = b0_q;
      if (state_q != IDLE && cs_rise) begin
         oe_d    = 1'b0;
         miso_d  = RST_MISO;
         done_d  = b0_q;
         abort_d = ~b0_q;
      end else begin
         case (state_q)
            IDLE: begin
               if (cs_fall) begin
                  oe_d   = 1'b1;
                  miso_d = 1'b0;
                  b0_d   = 1'b0;
               end
            end
            WAIT_START: if (sck_rise && mosi_s) cnt_d = 2'd0;
            CFG: begin
               // SGL/ODD are staged so an aborted command leaves cfg_* intact.
               if (sck_rise) begin
                  cnt_d = cnt_q + 2'd1;
                  case (cnt_q)
                     2'd0:    sgl_t_d = mosi_s;
                     2'd1:    odd_t_d = mosi_s;
                     default: begin
                        cfg_sgl_d  = sgl_t_q;
                        cfg_odd_d  = odd_t_q;
                        cfg_msbf_d = mosi_s;
                        sample_d   = smpl_new;
                        stb_d      = 1'b1;
                     end
                  endcase
               end
            end
            NULLB: begin
               if (sck_fall) begin
                  miso_d = 1'b0;
                  idx_d  = 4'd11;
               end
            end
            DATA: begin
               if (sck_fall) begin
                  miso_d = sample_q[idx_q];
                  if (idx_q == 4'd0) begin
                     b0_d  = 1'b1;
                     idx_d = 4'd1;
                  end else begin
                     idx_d = idx_q - 4'd1;
                  end
               end
            end
`ifdef MCP3202_SLV_LSBF_TAIL_EN
            TAIL_LSB: begin
               if (sck_fall) begin
                  miso_d = sample_q[idx_q];
                  idx_d  = idx_q + 4'd1;
               end
            end
`endif
            TAIL_ZERO: if (sck_fall) miso_d = 1'b0;
            default: ;
         endcase
      end
   end

   assign miso        = miso_q;
   assign miso_oe     = oe_q;
   assign smpl_stb    = stb_q;
   assign cfg_sgl     = cfg_sgl_q;
   assign cfg_odd     = cfg_odd_q;
   assign cfg_msbf    = cfg_msbf_q;
   assign frame_done  = done_q;
   assign frame_abort = abort_q;
   assign busy        = ~cs_s;

endmodule

// File: tb/tb_mcp3202_spi_slave.sv
`timescale 1ns/1ps
module tb_mcp3202_spi_slave;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cs = 1'b1, sck = 1'b1, mosi = 1'b0;
   logic        miso, miso_oe, smpl_stb, cfg_sgl, cfg_odd, cfg_msbf;
   logic        frame_done, frame_abort, busy;
   logic [11:0] ch0_data = 12'h000, ch1_data = 12'h000;

   int tests = 0;
   int fails = 0;

   typedef struct {
      string       name;
      bit          done;
      bit          chk_rx;
      logic [63:0] rx;
      int          nbits;
      int          stb;
      logic        sgl, odd, msbf;
   } exp_t;

   exp_t sb[$];

   always #5 clk = ~clk;

   mcp3202_spi_slave dut (
      .clk(clk), .rst_n(rst_n), .cs(cs), .sck(sck), .mosi(mosi),
      .miso(miso), .miso_oe(miso_oe),
      .ch0_data(ch0_data), .ch1_data(ch1_data),
      .smpl_stb(smpl_stb), .cfg_sgl(cfg_sgl), .cfg_odd(cfg_odd), .cfg_msbf(cfg_msbf),
      .frame_done(frame_done), .frame_abort(frame_abort), .busy(busy)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_miso"},  64'(miso), 64'd0);
      chk({tag, "_oe"},    64'(miso_oe), 64'd0);
      chk({tag, "_stb"},   64'(smpl_stb), 64'd0);
      chk({tag, "_done"},  64'(frame_done), 64'd0);
      chk({tag, "_abort"}, 64'(frame_abort), 64'd0);
      chk({tag, "_busy"},  64'(busy), 64'd0);
      chk({tag, "_cfg"},   64'({cfg_sgl, cfg_odd, cfg_msbf}), 64'd0);
   endtask

   task automatic expect_frame(input string name, input bit done, input bit chk_rx,
                               input logic [63:0] rx, input int nbits, input int stb,
                               input logic sgl, input logic odd, input logic msbf);
      exp_t e;
      e.name = name; e.done = done; e.chk_rx = chk_rx; e.rx = rx; e.nbits = nbits;
      e.stb = stb; e.sgl = sgl; e.odd = odd; e.msbf = msbf;
      sb.push_back(e);
   endtask

   // SPI master, mode 1,1: mosi changes with sck falling, miso is captured by
   // the monitor on sck rising. cmd = {START, SGL, ODD, MSBF}. rst_at >= 0
   // asserts rst_n before that sck cycle and abandons the frame.
   task automatic frame(input logic [3:0] cmd, input int lead, input int ncyc,
                        input int h, input int rst_at);
      int k;
      cs = 1'b0;
      repeat (4) @(negedge clk);
      for (int i = 0; i < ncyc; i++) begin
         if (i == rst_at) begin
            @(posedge clk); #2;
            rst_n = 1'b0;
            #1;
            chk_reset("rst_mid");
            cs = 1'b1; sck = 1'b1; mosi = 1'b0;
            repeat (4) @(negedge clk);
            rst_n = 1'b1;
            repeat (10) @(negedge clk);
            return;
         end
         k = i - lead;
         sck  = 1'b0;
         mosi = (k >= 0 && k < 4) ? cmd[3-k] : 1'b0;
         repeat (h) @(negedge clk);
         sck = 1'b1;
         repeat (h) @(negedge clk);
      end
      repeat (4) @(negedge clk);
      cs = 1'b1; mosi = 1'b0;
      repeat (10) @(negedge clk);
   endtask

   // Monitor: gathers miso on sck rising edges and, whenever the DUT reports
   // the end of a frame, pops the scoreboard and compares.
   initial begin
      logic        cs_l, sck_l;
      logic [63:0] rx;
      int          n, stb;
      exp_t        e;
      cs_l = 1'b1; sck_l = 1'b1; rx = '0; n = 0; stb = 0;
      forever begin
         @(posedge clk); #1;
         if (cs_l && !cs) begin rx = '0; n = 0; stb = 0; end
         if (!cs && sck && !sck_l) begin rx = {rx[62:0], miso}; n++; end
         if (smpl_stb) stb++;
         if (frame_done || frame_abort) begin
            if (sb.size() == 0) begin
               chk("unexpected_end_pulse", 64'({frame_done, frame_abort}), 64'd0);
            end else begin
               e = sb.pop_front();
               chk({e.name, "_done"},  64'(frame_done), 64'(e.done));
               chk({e.name, "_abort"}, 64'(frame_abort), 64'(!e.done));
               chk({e.name, "_oe_off"}, 64'(miso_oe), 64'd0);
               chk({e.name, "_miso_idle"}, 64'(miso), 64'd0);
               chk({e.name, "_stb_cnt"}, 64'(stb), 64'(e.stb));
               chk({e.name, "_cfg"}, 64'({cfg_sgl, cfg_odd, cfg_msbf}),
                   64'({e.sgl, e.odd, e.msbf}));
               if (e.chk_rx) begin
                  chk({e.name, "_rx"}, rx, e.rx);
                  chk({e.name, "_nbits"}, 64'(n), 64'(e.nbits));
               end
            end
         end
         cs_l = cs; sck_l = sck;
      end
   end

   initial begin
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk_reset("reset");
      rst_n = 1'b1;
      repeat (5) @(negedge clk);

      // Full 24-cycle frame: 5 zero bits, B11..B0, 7 tail zeros.
      ch0_data = 12'hA5C; ch1_data = 12'h000;
      expect_frame("f1_slow_ch0", 1, 1, 64'hA5C << 7, 24, 1, 1, 0, 1);
      frame(4'b1101, 0, 24, 450, -1);

      ch0_data = 12'hFFF; ch1_data = 12'h001;
      expect_frame("f2_ch1", 1, 1, 64'h001 << 7, 24, 1, 1, 1, 1);
      frame(4'b1111, 0, 24, 10, -1);

      ch0_data = 12'h100; ch1_data = 12'h300;
      expect_frame("f3_diff_clamp", 1, 1, 64'h0, 24, 1, 0, 0, 1);
      frame(4'b1001, 0, 24, 10, -1);

      expect_frame("f4_diff_pos", 1, 1, 64'h200 << 7, 24, 1, 0, 1, 1);
      frame(4'b1011, 0, 24, 10, -1);

      // MSBF=0, 28 cycles: after B0 comes B1..B11 (only B11 set) or zeros.
      ch0_data = 12'h801;
`ifdef MCP3202_SLV_LSBF_TAIL_EN
      expect_frame("f5_lsbf", 1, 1, (64'h801 << 11) | 64'h1, 28, 1, 1, 0, 0);
`else
      expect_frame("f5_lsbf", 1, 1, 64'h801 << 11, 28, 1, 1, 0, 0);
`endif
      frame(4'b1100, 0, 28, 10, -1);

      // Leading zeros only prepend zero bits; the numeric word is unchanged.
      ch0_data = 12'hA5C;
      expect_frame("f6_lead3_fast", 1, 1, 64'hA5C << 7, 27, 1, 1, 0, 1);
      frame(4'b1101, 3, 27, 4, -1);

      ch0_data = 12'h3C6;
      expect_frame("f7_fast", 1, 1, 64'h3C6 << 7, 24, 1, 1, 0, 1);
      frame(4'b1101, 0, 24, 4, -1);

      // Abort after the MSBF edge: sample latched, cfg updated, no B0.
      ch1_data = 12'h123;
      expect_frame("ab6", 0, 0, 64'h0, 0, 1, 1, 1, 1);
      frame(4'b1111, 0, 6, 10, -1);

      // Abort before MSBF: no strobe and cfg keeps the previous 1,1,1.
      expect_frame("ab2", 0, 0, 64'h0, 0, 0, 1, 1, 1);
      frame(4'b1000, 0, 2, 10, -1);

      ch0_data = 12'hA5C;
      expect_frame("recover", 1, 1, 64'hA5C << 7, 24, 1, 1, 0, 1);
      frame(4'b1101, 0, 24, 10, -1);

      // Reset during DATA: no end pulse is expected for this frame.
      frame(4'b1101, 0, 24, 10, 10);

      ch0_data = 12'h5A3;
      expect_frame("post_rst", 1, 1, 64'h5A3 << 7, 24, 1, 1, 0, 1);
      frame(4'b1101, 0, 24, 10, -1);

      repeat (20) @(negedge clk);
      chk("sb_drained", 64'(sb.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
